// File: rtl/shadow_mem_pkg.sv
// Shared types and default parameters for the shadow memory checker.
package shadow_mem_pkg;

    localparam int NUM_PORTS_DEF = 2;
    localparam int IDX_W_DEF     = 10;
    localparam int OUTST_DEF     = 4;
    localparam int CNT_W_DEF     = 16;
    localparam int LINE_W        = 256;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tag_e;

    typedef struct packed {
        tag_e        tag;
        logic [31:0] addr;
        logic [31:0] word;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/shadow_req_fifo.sv
// Synchronous DEPTH-entry request FIFO with full/empty; head is visible combinationally.
module shadow_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/shadow_mem_checker.sv
// Shadow memory that tracks per-port requests and checks DUT read responses.
// Optional first-mismatch log enabled by defining SHADOW_ERR_LOG_EN.
module shadow_mem_checker
    import shadow_mem_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int OUTST     = OUTST_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        read,
    input  logic [NUM_PORTS-1:0]        write,
    input  logic [NUM_PORTS-1:0][31:0]  address,
    input  logic [NUM_PORTS-1:0][31:0]  wdata,
    input  logic [NUM_PORTS-1:0][3:0]   mbe,
    input  logic [NUM_PORTS-1:0]        resp,
    input  logic [NUM_PORTS-1:0][31:0]  rdata,
    input  logic                        pl_we,
    input  logic [IDX_W-1:0]            pl_idx,
    input  logic [255:0]                pl_line,
    output logic [NUM_PORTS-1:0]        err_pulse,
    output logic [CNT_W-1:0]            err_count
`ifdef SHADOW_ERR_LOG_EN
    ,
    output logic                        err_log_valid,
    output logic [$clog2(NUM_PORTS)-1:0] err_log_port,
    output logic [31:0]                 err_log_addr,
    output logic [31:0]                 err_log_exp,
    output logic [31:0]                 err_log_got
`endif
);

    localparam int LINES  = 2 ** IDX_W;
    localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SUM_W  = CNT_W + $clog2(NUM_PORTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Each line is eight 32-bit words of four bytes, so byte lanes index directly.
    logic [7:0][3:0][7:0] mem_q [LINES];

    logic [NUM_PORTS-1:0][IDX_W-1:0] line_idx;
    logic [NUM_PORTS-1:0][2:0]       word_sel;
    logic [NUM_PORTS-1:0]            mism_d;
    logic [NUM_PORTS-1:0]            err_d;
    logic [NUM_PORTS-1:0]            err_pulse_q;
    logic [CNT_W-1:0]                err_cnt_q, err_cnt_d;
`ifdef SHADOW_ERR_LOG_EN
    logic [NUM_PORTS-1:0][31:0]      head_addr;
    logic [NUM_PORTS-1:0][31:0]      head_word;
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SUM_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + n;
        return (s > SUM_W'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ENTRY_W-1:0] head_bits;
        entry_t             ent, head;
        logic               req, push, pop, full, empty;
        logic               unused_bits;

        assign line_idx[p] = address[p][IDX_W+4:5];
        assign word_sel[p] = address[p][4:2];

        assign ent.tag  = write[p] ? WRITE : READ;
        assign ent.addr = address[p];
        assign ent.word = mem_q[line_idx[p]][word_sel[p]];
        assign head     = entry_t'(head_bits);

        assign req  = read[p] | write[p];
        assign pop  = resp[p] & ~empty & ~rst;
        assign push = req & (~full | pop) & ~rst;

        assign mism_d[p] = pop & (head.tag == READ) & (head.word != rdata[p]);
        assign err_d[p]  = ~rst & ((read[p] & write[p])
                                 | (req & full & ~pop)
                                 | (resp[p] & empty)
                                 | mism_d[p]);

        assign unused_bits = ^{address[p][31:IDX_W+5], address[p][1:0], head.addr};

`ifdef SHADOW_ERR_LOG_EN
        assign head_addr[p] = head.addr;
        assign head_word[p] = head.word;
`endif

        shadow_req_fifo #(
            .DEPTH (OUTST),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push),
            .pop_i   (pop),
            .din_i   (ent),
            .head_o  (head_bits),
            .full_o  (full),
            .empty_o (empty)
        );
    end

    // Later assignments win: port writes override preload, higher ports override lower.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (pl_we) begin
                mem_q[pl_idx] <= pl_line;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (write[PIDX_W'(p)]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mbe[PIDX_W'(p)][2'(b)]) begin
                            mem_q[line_idx[PIDX_W'(p)]][word_sel[PIDX_W'(p)]][2'(b)]
                                <= wdata[PIDX_W'(p)][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        err_cnt_d = sat_add(err_cnt_q, SUM_W'($countones(err_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

`ifdef SHADOW_ERR_LOG_EN
    logic                         log_valid_q;
    logic [$clog2(NUM_PORTS)-1:0] log_port_q, log_port_d;
    logic [31:0]                  log_addr_q, log_addr_d;
    logic [31:0]                  log_exp_q, log_exp_d;
    logic [31:0]                  log_got_q, log_got_d;

    // Scan downward so the lowest mismatching port is the one left selected.
    always_comb begin
        log_port_d = '0;
        log_addr_d = '0;
        log_exp_d  = '0;
        log_got_d  = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (mism_d[PIDX_W'(p)]) begin
                log_port_d = $clog2(NUM_PORTS)'(p);
                log_addr_d = head_addr[PIDX_W'(p)];
                log_exp_d  = head_word[PIDX_W'(p)];
                log_got_d  = rdata[PIDX_W'(p)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_valid_q <= 1'b0;
            log_port_q  <= '0;
            log_addr_q  <= '0;
            log_exp_q   <= '0;
            log_got_q   <= '0;
        end else if (!log_valid_q && (|mism_d)) begin
            log_valid_q <= 1'b1;
            log_port_q  <= log_port_d;
            log_addr_q  <= log_addr_d;
            log_exp_q   <= log_exp_d;
            log_got_q   <= log_got_d;
        end
    end

    assign err_log_valid = log_valid_q;
    assign err_log_port  = log_port_q;
    assign err_log_addr  = log_addr_q;
    assign err_log_exp   = log_exp_q;
    assign err_log_got   = log_got_q;
`endif

endmodule

// File: doc/shadow_mem_checker.md
SHADOW_MEM_CHECKER -- requirements
Module: shadow_mem_checker

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of independent memory ports monitored; port 0 is instruction, port 1 is data.
REQ-002 Parameter IDX_W, default 10: line-index width; the array holds 2**IDX_W lines of 256 bits.
REQ-003 Parameter OUTST, default 4: outstanding requests tracked per port, power of two.
REQ-004 Parameter CNT_W, default 16: error-counter width.
REQ-005 clk  in  1: sole clock; all logic samples on its rising edge.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 read  in  [NUM_PORTS]: per-port read request, one-cycle strobe.
REQ-008 write  in  [NUM_PORTS]: per-port write request, one-cycle strobe.
REQ-009 address  in  [NUM_PORTS][32]: request byte address, word-aligned.
REQ-010 wdata  in  [NUM_PORTS][32]: write data.
REQ-011 mbe  in  [NUM_PORTS][4]: write byte enables.
REQ-012 resp  in  [NUM_PORTS]: DUT response strobe, one per request, in order.
REQ-013 rdata  in  [NUM_PORTS][32]: DUT read data, valid with resp.
REQ-014 pl_we, pl_idx, pl_line  in  1, IDX_W, 256: preload write of one array line.
REQ-015 err_pulse  out  [NUM_PORTS]: one-cycle flag per detected error.
REQ-016 err_count  out  CNT_W: total errors, saturating.

Function
REQ-017 Line index is address[IDX_W+4:5]; word select is address[4:2]; upper bits are ignored.
REQ-018 On read, the addressed word is captured into that port's FIFO with tag READ in the same cycle.
REQ-019 On write, the enabled bytes update the array at the clock edge, and an entry with tag WRITE is pushed.
REQ-020 Read and write asserted together on one port is an error; the write is performed, and a WRITE entry is pushed.
REQ-021 All reads in a cycle observe array contents from before that cycle's writes and preload.
REQ-022 Same-cycle writes to the same word merge per byte, with the higher port index winning.
REQ-023 A preload in the same cycle as a port write to the same line is overridden by the port write, per byte.
REQ-024 On resp, the head entry is popped; for a READ tag, rdata is compared with the captured word; a mismatch is an error.
REQ-025 A resp and a new request on the same port in the same cycle both take effect; a resp to a request issued in that same cycle is not allowed.
REQ-026 A resp with an empty FIFO is an error (spurious response); nothing is popped.
REQ-027 A request with a full FIFO and no same-cycle pop is an error (overflow); the request is not tracked, but its write still updates the array.
REQ-028 err_pulse[p] is registered: it asserts the cycle after an error on port p.
REQ-029 err_count adds the number of ports in error that cycle, saturating at 2**CNT_W-1.
REQ-030 Latency from request to compare readiness is zero; a resp may arrive the cycle after the request.

Reset
REQ-031 rst clears FIFO pointers and occupancy, err_pulse to 0, err_count to 0, and log registers.
REQ-032 rst does not clear array contents; preload remains the only initialisation path.
REQ-033 Requests, responses and preloads in a reset cycle are ignored; tracked requests outstanding at reset are discarded.

Configuration
REQ-034 With SHADOW_ERR_LOG_EN defined, the block adds outputs err_log_valid (1), err_log_port ($clog2(NUM_PORTS)), err_log_addr (32), err_log_exp (32) and err_log_got (32).
REQ-035 With SHADOW_ERR_LOG_EN defined, the log captures the first mismatch after reset and holds it until reset; at equal time, the lowest port wins.
REQ-036 Without SHADOW_ERR_LOG_EN, these outputs and their registers do not exist, and all other behaviour is unchanged.

Structure
REQ-037 Package shadow_mem_pkg holds typedef line_t (256 bits), the tag enum (READ, WRITE), the entry struct {tag, addr, word} and the default-parameter constants.
REQ-038 Sub-module shadow_req_fifo (a synchronous OUTST-deep FIFO with full and empty) is instantiated once per port.

Verification
REQ-039 Preload line 0 = {8{32'hA5A5_0000}}; port 0 reads 0x0000_0004, then resp with rdata 32'hA5A5_0000 -> no err_pulse, err_count 0.
REQ-040 Port 1 writes 0x0000_0020 with wdata 32'h1234_5678 and mbe 4'b0011; port 0 then reads that address over line preloaded 0 -> expected word 32'h0000_5678; DUT returns 32'h1234_5678 -> err_pulse[0], err_count 1.
REQ-041 Port 0 issues 5 reads with no resp, OUTST=4 -> fifth flags overflow; 4 resps then complete cleanly, err_count 1.
REQ-042 resp on port 1 with empty FIFO -> err_pulse[1] the next cycle, err_count +1.
REQ-043 Ports 0 and 1 write the same word in the same cycle with full mbe, values 32'h1 and 32'h2 -> a later read expects 32'h2.
REQ-044 rst asserted with 3 reads outstanding, then a resp -> spurious error flagged; err_count was 0 after reset, now 1; with SHADOW_ERR_LOG_EN, err_log_valid stays 0.
